// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline CPU: ALU opcode encoding and the
// iterative multiplier state encoding.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mulState_t;

endpackage

// File: rtl/iter_multiplier.sv
// Shift-and-add 32x32 multiplier producing the low 32 product bits after
// 32 iterations; only built when EX_MUL_EN is defined.
module iter_multiplier
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mulState_t   state, nextState;
  logic [31:0] mcand, mplier, acc;
  logic [4:0]  cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= MUL_IDLE;
    else     state <= nextState;
  end

  // NOTE: nextState takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      MUL_IDLE: if (start) nextState = MUL_RUN;
      MUL_RUN:  if (cnt == 5'd31) nextState = MUL_DONE;
      MUL_DONE: nextState = MUL_IDLE;
      default:  nextState = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        MUL_IDLE: if (start) begin
          mcand  <= a;
          mplier <= b;
          acc    <= '0;
          cnt    <= '0;
        end
        MUL_RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Busy covers the launch cycle too, so upstream holds from the first cycle.
  assign busy    = ((state == MUL_IDLE) && start) || (state == MUL_RUN);
  assign done    = (state == MUL_DONE);
  assign product = acc;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM pipeline register. Define EX_MUL_EN to build the
// iterative multiplier; otherwise opcode 12 yields 0 and ex_busy is tied low.
module ex_mem_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_shiftAmount,
  input  logic [31:0] ex_immediate,
  input  logic [31:0] ex_registerRsOrPc_4,
  input  logic [31:0] ex_registerRtOrZero,
  input  logic [3:0]  ex_aluOperation,
  input  logic [4:0]  ex_registerWriteBackDestination,
  input  logic        ex_ifWriteRegsFile,
  input  logic        ex_ifWriteMem,
  input  logic        ex_memOutOrAluOutWriteBackToRegFile,
  input  logic        ex_whileShiftAluInput_A_UseShamt,
  input  logic        ex_aluInput_B_UseRtOrImmeidate,
  output logic        ex_busy,
  output logic [31:0] mem_aluResult,
  output logic [31:0] mem_storeData,
  output logic [4:0]  mem_registerWriteBackDestination,
  output logic        mem_ifWriteRegsFile,
  output logic        mem_ifWriteMem,
  output logic        mem_memOutOrAluOutWriteBackToRegFile
);

  logic [31:0] aluA, aluB, aluResult, loadValue;

  assign aluA = ex_whileShiftAluInput_A_UseShamt ? ex_shiftAmount : ex_registerRsOrPc_4;
  assign aluB = ex_aluInput_B_UseRtOrImmeidate ? ex_immediate : ex_registerRtOrZero;

  always_comb begin
    aluResult = '0;
    case (ex_aluOperation)
      ALU_ADD:  aluResult = aluA + aluB;
      ALU_SUB:  aluResult = aluA - aluB;
      ALU_AND:  aluResult = aluA & aluB;
      ALU_OR:   aluResult = aluA | aluB;
      ALU_XOR:  aluResult = aluA ^ aluB;
      ALU_NOR:  aluResult = ~(aluA | aluB);
      ALU_SLT:  aluResult = {31'b0, $signed(aluA) < $signed(aluB)};
      ALU_SLTU: aluResult = {31'b0, aluA < aluB};
      ALU_SLL:  aluResult = aluB << aluA[4:0];
      ALU_SRL:  aluResult = aluB >> aluA[4:0];
      ALU_SRA:  aluResult = $signed(aluB) >>> aluA[4:0];
      ALU_LUI:  aluResult = aluB << 16;
      default:  aluResult = '0;
    endcase
  end

`ifdef EX_MUL_EN
  logic        mulDone;
  logic [31:0] mulProduct;

  iter_multiplier multiplier (
    .clk     (clk),
    .rst     (rst),
    .start   (ex_aluOperation == ALU_MUL),
    .a       (aluA),
    .b       (aluB),
    .busy    (ex_busy),
    .done    (mulDone),
    .product (mulProduct)
  );

  // In DONE the held MUL instruction is still on the ID/EX bus.
  assign loadValue = mulDone ? mulProduct : aluResult;
`else
  assign ex_busy   = 1'b0;
  assign loadValue = aluResult;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_aluResult                        <= '0;
      mem_storeData                        <= '0;
      mem_registerWriteBackDestination     <= '0;
      mem_ifWriteRegsFile                  <= 1'b0;
      mem_ifWriteMem                       <= 1'b0;
      mem_memOutOrAluOutWriteBackToRegFile <= 1'b0;
    end else begin
      mem_aluResult                        <= loadValue;
      mem_storeData                        <= ex_registerRtOrZero;
      mem_registerWriteBackDestination     <= ex_registerWriteBackDestination;
      // A stalled multiply pushes bubbles: no write enables reach MEM.
      mem_ifWriteRegsFile                  <= ex_ifWriteRegsFile & ~ex_busy;
      mem_ifWriteMem                       <= ex_ifWriteMem & ~ex_busy;
      mem_memOutOrAluOutWriteBackToRegFile <= ex_memOutOrAluOutWriteBackToRegFile & ~ex_busy;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expectations are queued when an
// instruction is driven and popped when its result reaches the mem_* side.
module tb_ex_mem_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_shiftAmount, ex_immediate, ex_registerRsOrPc_4, ex_registerRtOrZero;
  logic [3:0]  ex_aluOperation;
  logic [4:0]  ex_registerWriteBackDestination;
  logic        ex_ifWriteRegsFile, ex_ifWriteMem, ex_memOutOrAluOutWriteBackToRegFile;
  logic        ex_whileShiftAluInput_A_UseShamt, ex_aluInput_B_UseRtOrImmeidate;
  logic        ex_busy;
  logic [31:0] mem_aluResult, mem_storeData;
  logic [4:0]  mem_registerWriteBackDestination;
  logic        mem_ifWriteRegsFile, mem_ifWriteMem, mem_memOutOrAluOutWriteBackToRegFile;

  typedef struct {
    logic [31:0] result;
    logic [31:0] storeData;
    logic [4:0]  dest;
    logic [2:0]  ctrl;
  } expect_t;

  expect_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int vecIdx = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk                                  (clk),
    .rst                                  (rst),
    .ex_shiftAmount                       (ex_shiftAmount),
    .ex_immediate                         (ex_immediate),
    .ex_registerRsOrPc_4                  (ex_registerRsOrPc_4),
    .ex_registerRtOrZero                  (ex_registerRtOrZero),
    .ex_aluOperation                      (ex_aluOperation),
    .ex_registerWriteBackDestination      (ex_registerWriteBackDestination),
    .ex_ifWriteRegsFile                   (ex_ifWriteRegsFile),
    .ex_ifWriteMem                        (ex_ifWriteMem),
    .ex_memOutOrAluOutWriteBackToRegFile  (ex_memOutOrAluOutWriteBackToRegFile),
    .ex_whileShiftAluInput_A_UseShamt     (ex_whileShiftAluInput_A_UseShamt),
    .ex_aluInput_B_UseRtOrImmeidate       (ex_aluInput_B_UseRtOrImmeidate),
    .ex_busy                              (ex_busy),
    .mem_aluResult                        (mem_aluResult),
    .mem_storeData                        (mem_storeData),
    .mem_registerWriteBackDestination     (mem_registerWriteBackDestination),
    .mem_ifWriteRegsFile                  (mem_ifWriteRegsFile),
    .mem_ifWriteMem                       (mem_ifWriteMem),
    .mem_memOutOrAluOutWriteBackToRegFile (mem_memOutOrAluOutWriteBackToRegFile)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  function automatic logic [2:0] memCtrl();
    return {mem_ifWriteRegsFile, mem_ifWriteMem, mem_memOutOrAluOutWriteBackToRegFile};
  endfunction

  task automatic driveIdle();
    ex_shiftAmount = '0; ex_immediate = '0; ex_registerRsOrPc_4 = '0; ex_registerRtOrZero = '0;
    ex_aluOperation = '0; ex_registerWriteBackDestination = '0;
    ex_ifWriteRegsFile = 0; ex_ifWriteMem = 0; ex_memOutOrAluOutWriteBackToRegFile = 0;
    ex_whileShiftAluInput_A_UseShamt = 0; ex_aluInput_B_UseRtOrImmeidate = 0;
  endtask

  task automatic popAndCheck(input string tag);
    expect_t e;
    if (sb.size() == 0) begin
      checkVal({tag, "_sbEmpty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkVal({tag, "_result"}, mem_aluResult, e.result);
    checkVal({tag, "_store"},  mem_storeData, e.storeData);
    checkVal({tag, "_dest"},   {27'b0, mem_registerWriteBackDestination}, {27'b0, e.dest});
    checkVal({tag, "_ctrl"},   {29'b0, memCtrl()}, {29'b0, e.ctrl});
  endtask

  // Single-cycle vector: called at a negedge, returns at the following negedge.
  task automatic runVec(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] imm, input logic [31:0] shamt,
                        input logic useShamt, input logic useImm, input logic [31:0] expResult);
    expect_t e;
    logic [2:0] ctrl;
    ctrl = 3'(vecIdx % 7 + 1);
    ex_aluOperation = op; ex_registerRsOrPc_4 = rs; ex_registerRtOrZero = rt;
    ex_immediate = imm; ex_shiftAmount = shamt;
    ex_whileShiftAluInput_A_UseShamt = useShamt; ex_aluInput_B_UseRtOrImmeidate = useImm;
    ex_registerWriteBackDestination = 5'(vecIdx + 3);
    {ex_ifWriteRegsFile, ex_ifWriteMem, ex_memOutOrAluOutWriteBackToRegFile} = ctrl;
    e.result = expResult; e.storeData = rt; e.dest = 5'(vecIdx + 3); e.ctrl = ctrl;
    sb.push_back(e);
    vecIdx++;
    #1 checkVal({tag, "_busy"}, {31'b0, ex_busy}, 32'd0);
    @(posedge clk); @(negedge clk);
    popAndCheck(tag);
  endtask

`ifdef EX_MUL_EN
  // Multiply with upstream held while busy; returns at the negedge after the
  // product lands, i.e. the first cycle in which the next op can be presented.
  task automatic runMul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input logic [31:0] expProduct);
    expect_t e;
    int busyCount = 0;
    ex_aluOperation = ALU_MUL; ex_registerRsOrPc_4 = a; ex_registerRtOrZero = b;
    ex_immediate = 32'hDEAD_0000; ex_shiftAmount = 32'd7;
    ex_whileShiftAluInput_A_UseShamt = 0; ex_aluInput_B_UseRtOrImmeidate = 0;
    ex_registerWriteBackDestination = dest;
    ex_ifWriteRegsFile = 1; ex_ifWriteMem = 0; ex_memOutOrAluOutWriteBackToRegFile = 0;
    e.result = expProduct; e.storeData = b; e.dest = dest; e.ctrl = 3'b100;
    sb.push_back(e);
    for (int cyc = 0; cyc <= 33; cyc++) begin
      #1;
      if (ex_busy) busyCount++;
      if (cyc == 0 || cyc == 32 || cyc == 33)
        checkVal($sformatf("%s_busyCyc%0d", tag, cyc), {31'b0, ex_busy}, {31'b0, cyc <= 32});
      @(posedge clk); @(negedge clk);
      if (cyc <= 32 && memCtrl() != 3'b000)
        checkVal($sformatf("%s_bubbleCyc%0d", tag, cyc), {29'b0, memCtrl()}, 32'd0);
    end
    checkVal({tag, "_busyCount"}, busyCount, 32'd33);
    popAndCheck(tag);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic wroteAfterReset;
    // Reset with live-looking inputs: the register must still read 0.
    rst = 1;
    driveIdle();
    ex_registerRsOrPc_4 = 32'h1234_5678; ex_registerRtOrZero = 32'h0000_0011;
    ex_registerWriteBackDestination = 5'd7;
    ex_ifWriteRegsFile = 1; ex_ifWriteMem = 1; ex_memOutOrAluOutWriteBackToRegFile = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rst_result", mem_aluResult, 32'd0);
    checkVal("rst_store",  mem_storeData, 32'd0);
    checkVal("rst_dest",   {27'b0, mem_registerWriteBackDestination}, 32'd0);
    checkVal("rst_ctrl",   {29'b0, memCtrl()}, 32'd0);
    rst = 0;
    driveIdle();
    @(posedge clk); @(negedge clk);
    checkVal("idle_result", mem_aluResult, 32'd0);
    checkVal("idle_ctrl",   {29'b0, memCtrl()}, 32'd0);
    checkVal("idle_busy",   {31'b0, ex_busy}, 32'd0);

    runVec("add_wrap", ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0055, 32'd1, 32'd9, 0, 1, 32'h8000_0000);
    runVec("add_rt",   ALU_ADD,  32'hFFFF_FFFF, 32'd2, 32'd100, 32'd0, 0, 0, 32'h0000_0001);
    runVec("sub",      ALU_SUB,  32'd5, 32'd7, 32'd0, 32'd0, 0, 0, 32'hFFFF_FFFE);
    runVec("and",      ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 0, 0, 32'hF000_F000);
    runVec("or",       ALU_OR,   32'hF0F0_0000, 32'h0000_00FF, 32'h0F00_0000, 32'd0, 0, 1, 32'hFFF0_0000);
    runVec("xor",      ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 32'd0, 0, 0, 32'h5555_5555);
    runVec("nor",      ALU_NOR,  32'hF000_000F, 32'h0F00_00F0, 32'd0, 32'd0, 0, 0, 32'h00FF_FF00);
    runVec("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 0, 32'd1);
    runVec("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 0, 32'd0);
    runVec("sll",      ALU_SLL,  32'd8, 32'h0000_0001, 32'd0, 32'd4, 1, 0, 32'h0000_0010);
    runVec("srl",      ALU_SRL,  32'd8, 32'hF000_0000, 32'd0, 32'd4, 1, 0, 32'h0F00_0000);
    runVec("sra",      ALU_SRA,  32'd8, 32'hF000_0000, 32'd0, 32'd4, 1, 0, 32'hFF00_0000);
    runVec("lui",      ALU_LUI,  32'd3, 32'h0000_0099, 32'h0000_1234, 32'd0, 0, 1, 32'h1234_0000);
    runVec("op13",     4'd13,    32'h1111_1111, 32'h2222_2222, 32'd0, 32'd0, 0, 0, 32'd0);
    runVec("op15",     4'd15,    32'h1111_1111, 32'h2222_2222, 32'd0, 32'd0, 0, 0, 32'd0);

`ifdef EX_MUL_EN
    runMul("mul", 32'h1234_5678, 32'h0000_0010, 5'd9, 32'h2345_6780);
    runMul("mul_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'h0000_0001);

    // Reset pulsed in cycle 10 of a multiply; op drops to 0 with it.
    ex_aluOperation = ALU_MUL; ex_registerRsOrPc_4 = 32'd6; ex_registerRtOrZero = 32'd7;
    ex_registerWriteBackDestination = 5'd4; ex_ifWriteRegsFile = 1;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    rst = 1;
    driveIdle();
    @(posedge clk); @(negedge clk);
    rst = 0;
    #1 checkVal("rstmul_busy", {31'b0, ex_busy}, 32'd0);
    checkVal("rstmul_result", mem_aluResult, 32'd0);
    checkVal("rstmul_ctrl", {29'b0, memCtrl()}, 32'd0);
    wroteAfterReset = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (mem_ifWriteRegsFile || mem_aluResult == 32'd42) wroteAfterReset = 1;
    end
    checkVal("rstmul_noWrite", {31'b0, wroteAfterReset}, 32'd0);
    runMul("mul_afterRst", 32'd3, 32'd5, 5'd30, 32'd15);
`else
    runVec("mul_off", ALU_MUL, 32'h1234_5678, 32'h0000_0010, 32'd0, 32'd0, 0, 0, 32'd0);
    ex_aluOperation = ALU_MUL;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      checkVal("mul_off_busy", {31'b0, ex_busy}, 32'd0);
    end
`endif

    checkVal("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
